pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Sequential program-counter unit for the single-issue RISC-V core; a parametrised successor to the combinational next-PC logic.
- Owns the architectural PC register and drives fetch addresses to instruction memory with a valid/ready handshake.
- Resolves branch/JAL/JALR redirects from EX, raises a pipeline flush, and traps on misaligned targets.
- Sits between the EX stage and the instruction-memory port.

Parameters:
- XLEN, 32, datapath and PC width in bits.
- RESET_VEC, 32'h0000_0000, PC loaded on reset; XLEN-wide, must be 4-byte aligned.
- TRAP_VEC, 32'h0000_0100, PC loaded on a misaligned-target trap; 4-byte aligned.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- ex_valid  in  1  EX stage holds a valid instruction this cycle.
- ex_pc  in  XLEN  PC of the instruction in EX.
- branch  in  3  000 none, 001 taken-if-!zero (BNE/BLT/BLTU), 010 taken-if-zero (BEQ/BGE/BGEU), 011 JAL, 100 JALR, 101-111 none.
- zero  in  1  ALU compare flag.
- immgen  in  XLEN  sign-extended immediate.
- aluout  in  XLEN  ALU result, used as the JALR target.
- stall  in  1  hazard stall; hold the PC.
- if_ready  in  1  instruction memory accepts the address.
- if_valid  out  1  fetch address valid.
- pc  out  XLEN  current fetch PC (registered).
- pc_4  out  XLEN  pc + 4 (combinational).
- flush  out  1  kill IF/ID contents (combinational, same cycle as the redirect).
- trap  out  1  one-cycle pulse, misaligned target.
- trap_pc  out  XLEN  ex_pc of the trapping instruction (registered, sticky).
- perf_taken  out  32  redirect count (PC_PERF_EN only).
- perf_stall  out  32  stalled-cycle count (PC_PERF_EN only).

Behaviour:
- States: BOOT, RUN, TRAP.
- Reset (any state, any cycle, including mid-fetch):
  - pc=RESET_VEC, state=BOOT, if_valid=0, trap=0, trap_pc=0, perf counters=0.
  - flush is combinational: 0 while reset=1.
- BOOT: if_valid=0 for exactly one cycle, then RUN.
- RUN: if_valid=1.
- Target selection:
  - Types 001/010/011: target = ex_pc + immgen.
  - Type 100: target = aluout & ~1.
  - Additions wrap modulo 2^XLEN.
- Redirect condition: ex_valid and (001 & !zero | 010 & zero | 011 | 100).
- Misaligned: a redirect whose target[1] = 1 (target[0] is 0 by construction or immediate format).
- Priority per cycle, highest first:
  1. reset.
  2. Redirect misaligned:
     - flush=1, pc<=TRAP_VEC, trap_pc<=ex_pc.
     - state<=TRAP (trap=1 in the next cycle); if_valid=0 in the TRAP cycle, then RUN.
  3. Redirect aligned: flush=1, pc<=target; stall and if_ready are ignored.
  4. stall=1: pc held.
  5. if_valid & if_ready: pc<=pc+4.
  6. Otherwise pc held.
- A redirect during TRAP or BOOT is ignored (EX is flushed); no flush is asserted.
- Latency:
  - Redirect visible on pc one cycle after ex_valid.
  - The sequential advance is one cycle per accepted handshake.
- pc+4 at 2^XLEN-4 wraps to 0, with no error.
- pc_4 tracks the registered pc at all times.

Optional Feature:
- Macro PC_PERF_EN.
- Defined:
  - perf_taken increments on each aligned or misaligned redirect.
  - perf_stall increments each RUN cycle with stall=1 and no redirect.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: counter logic is absent and both ports are tied to 0. The port list is unchanged.

Decomposition:
- Package pc_pkg:
  - Branch encoding constants BR_NONE, BR_NE, BR_EQ, BR_JAL, BR_JALR.
  - State enum pc_state_t (BOOT, RUN, TRAP).
  - Default vector constants.
- Sub-module pc_target_calc (combinational):
  - Inputs: branch, zero, ex_valid, ex_pc, immgen, aluout.
  - Outputs: redirect, target, misaligned.
- pc_fetch_ctrl holds the state, the PC register, trap_pc and the counters.

Test Plan:
- Reset, then release with if_ready=1 → pc=0 for 2 cycles (BOOT + first fetch), then 4, 8, 12; if_valid low only in the BOOT cycle.
- pc=0x20, if_ready=0 for 3 cycles → pc holds 0x20; if_ready=1 → 0x24. stall=1 with if_ready=1 → pc holds.
- ex_valid, branch=010, zero=1, ex_pc=0x40, immgen=-8 → flush=1 the same cycle, pc=0x38 next cycle. Same with zero=0 → no flush, sequential.
- branch=100, aluout=0x1235, stall=1 → flush=1, pc=0x1234 (redirect beats stall).
- branch=011, ex_pc=0x80, immgen=0x6 → pc=0x100, trap=1 one cycle later, trap_pc=0x80, if_valid=0 in the TRAP cycle. With PC_PERF_EN, perf_taken=1.
- pc=0xFFFF_FFFC, handshake → pc=0. reset asserted during a stall → pc=RESET_VEC next cycle, counters=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter / fetch controller.
package pc_pkg;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_NE   = 3'b001;
  localparam logic [2:0] BR_EQ   = 3'b010;
  localparam logic [2:0] BR_JAL  = 3'b011;
  localparam logic [2:0] BR_JALR = 3'b100;

  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC_DEF  = 32'h0000_0100;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    TRAP
  } pc_state_t;

endpackage

// File: rtl/pc_target_calc.sv
// Redirect decision and target address for branch/JAL/JALR in EX.
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      branch,
  input  logic            zero,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] immgen,
  input  logic [XLEN-1:0] aluout,
  output logic            redirect,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  logic [XLEN-1:0] rel;
  logic            taken;

  assign rel = ex_pc + immgen;

  always_comb begin
    taken  = 1'b0;
    target = rel;
    unique case (1'b1)
      (branch == BR_NE):  taken = ~zero;
      (branch == BR_EQ):  taken = zero;
      (branch == BR_JAL): taken = 1'b1;
      (branch == BR_JALR): begin
        taken  = 1'b1;
        target = aluout & ~XLEN'(1);
      end
      default: taken = 1'b0;
    endcase
    redirect   = ex_valid & taken;
    misaligned = redirect & target[1];
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register, fetch handshake, redirect/flush and misaligned trap.
// Optional counters enabled by defining PC_PERF_EN.
module pc_fetch_ctrl
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(TRAP_VEC_DEF)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [2:0]      branch,
  input  logic            zero,
  input  logic [XLEN-1:0] immgen,
  input  logic [XLEN-1:0] aluout,
  input  logic            stall,
  input  logic            if_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_4,
  output logic            flush,
  output logic            trap,
  output logic [XLEN-1:0] trap_pc,
  output logic [31:0]     perf_taken,
  output logic [31:0]     perf_stall
);

  pc_state_t       state;
  logic            redirect;
  logic            misaligned;
  logic [XLEN-1:0] target;
  logic            run;
  logic            take;

  pc_target_calc #(
    .XLEN(XLEN)
  ) u_calc (
    .branch    (branch),
    .zero      (zero),
    .ex_valid  (ex_valid),
    .ex_pc     (ex_pc),
    .immgen    (immgen),
    .aluout    (aluout),
    .redirect  (redirect),
    .target    (target),
    .misaligned(misaligned)
  );

  // EX is flushed outside RUN, so redirects only count there.
  assign run      = (state == RUN);
  assign take     = run & redirect;
  assign flush    = ~reset & take;
  assign if_valid = run;
  assign trap     = (state == TRAP);
  assign pc_4     = pc + XLEN'(4);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= BOOT;
      pc      <= RESET_VEC;
      trap_pc <= '0;
    end else begin
      unique case (state)
        BOOT: state <= RUN;
        TRAP: state <= RUN;
        RUN: begin
          if (take && misaligned) begin
            pc      <= TRAP_VEC;
            trap_pc <= ex_pc;
            state   <= TRAP;
          end else if (take) begin
            pc <= target;
          end else if (!stall && if_ready) begin
            pc <= pc_4;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

`ifdef PC_PERF_EN
  logic [31:0] taken_q;
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      taken_q <= '0;
      stall_q <= '0;
    end else begin
      if (take && taken_q != '1)
        taken_q <= taken_q + 32'd1;
      if (run && stall && !take && stall_q != '1)
        stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_taken = taken_q;
  assign perf_stall = stall_q;
`else
  assign perf_taken = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a per-cycle reference model.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [2:0]  branch;
  logic        zero;
  logic [31:0] immgen;
  logic [31:0] aluout;
  logic        stall;
  logic        if_ready;
  logic        if_valid;
  logic [31:0] pc;
  logic [31:0] pc_4;
  logic        flush;
  logic        trap;
  logic [31:0] trap_pc;
  logic [31:0] perf_taken;
  logic [31:0] perf_stall;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 = boot, 1 = fetching, 2 = trap bubble
  bit          m_known = 0;
  int          m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_trap_pc;
  logic [31:0] m_taken;
  logic [31:0] m_stall;

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .ex_valid  (ex_valid),
    .ex_pc     (ex_pc),
    .branch    (branch),
    .zero      (zero),
    .immgen    (immgen),
    .aluout    (aluout),
    .stall     (stall),
    .if_ready  (if_ready),
    .if_valid  (if_valid),
    .pc        (pc),
    .pc_4      (pc_4),
    .flush     (flush),
    .trap      (trap),
    .trap_pc   (trap_pc),
    .perf_taken(perf_taken),
    .perf_stall(perf_stall)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic decide(output bit r, output logic [31:0] t);
    t = ex_pc + immgen;
    r = 0;
    if (ex_valid) begin
      case (branch)
        3'b001: r = !zero;
        3'b010: r = zero;
        3'b011: r = 1;
        3'b100: begin
          r = 1;
          t = aluout & 32'hFFFF_FFFE;
        end
        default: r = 0;
      endcase
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_cycle();
    bit          r;
    logic [31:0] t;
    logic [31:0] e_tk;
    logic [31:0] e_st;
`ifdef PC_PERF_EN
    e_tk = m_taken;
    e_st = m_stall;
`else
    e_tk = 0;
    e_st = 0;
`endif
    decide(r, t);
    if (m_known) begin
      chk("m_pc", pc, m_pc);
      chk("m_pc_4", pc_4, m_pc + 32'd4);
      chk("m_if_valid", {31'b0, if_valid}, {31'b0, m_phase == 1});
      chk("m_trap", {31'b0, trap}, {31'b0, m_phase == 2});
      chk("m_trap_pc", trap_pc, m_trap_pc);
      chk("m_perf_taken", perf_taken, e_tk);
      chk("m_perf_stall", perf_stall, e_st);
    end
    if (m_known || reset)
      chk("m_flush", {31'b0, flush},
          {31'b0, !reset && m_known && m_phase == 1 && r});
    if (reset) begin
      m_known   = 1;
      m_phase   = 0;
      m_pc      = 32'h0;
      m_trap_pc = 32'h0;
      m_taken   = 0;
      m_stall   = 0;
    end else if (m_known) begin
      if (m_phase != 1) begin
        m_phase = 1;
      end else if (r) begin
        m_taken = sat_inc(m_taken);
        if (t[1]) begin
          m_pc      = 32'h100;
          m_trap_pc = ex_pc;
          m_phase   = 2;
        end else begin
          m_pc = t;
        end
      end else if (stall) begin
        m_stall = sat_inc(m_stall);
      end else if (if_ready) begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_br(input logic [2:0] b, input logic z,
                        input logic [31:0] epc, input logic [31:0] imm,
                        input logic [31:0] alu);
    ex_valid = 1;
    branch   = b;
    zero     = z;
    ex_pc    = epc;
    immgen   = imm;
    aluout   = alu;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1;
    ex_valid = 0;
    ex_pc    = 0;
    branch   = 0;
    zero     = 0;
    immgen   = 0;
    aluout   = 0;
    stall    = 0;
    if_ready = 1;
    tick();
    tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_trap", {31'b0, trap}, 32'h0);
    chk("rst_trap_pc", trap_pc, 32'h0);

    reset = 0;
    tick();
    chk("first_fetch_pc", pc, 32'h0);
    chk("first_fetch_valid", {31'b0, if_valid}, 32'h1);
    tick();
    chk("seq_pc_4", pc, 32'h4);
    tick();
    chk("seq_pc_8", pc, 32'h8);
    tick();
    chk("seq_pc_c", pc, 32'hC);

    set_br(3'b011, 0, 32'h0, 32'h20, 32'h0);
    if_ready = 0;
    #1;
    chk("jal_flush", {31'b0, flush}, 32'h1);
    tick();
    ex_valid = 0;
    for (int i = 0; i < 3; i++) tick();
    chk("not_ready_hold", pc, 32'h20);
    if_ready = 1;
    tick();
    chk("ready_adv", pc, 32'h24);
    stall = 1;
    tick();
    tick();
    chk("stall_hold", pc, 32'h24);
    stall = 0;

    set_br(3'b010, 1, 32'h40, 32'hFFFF_FFF8, 32'h0);
    #1;
    chk("beq_flush", {31'b0, flush}, 32'h1);
    tick();
    chk("beq_target", pc, 32'h38);
    zero = 0;
    #1;
    chk("beq_nt_flush", {31'b0, flush}, 32'h0);
    tick();
    chk("beq_nt_seq", pc, 32'h3C);

    set_br(3'b100, 0, 32'h0, 32'h1235, 32'h1235);
    stall = 1;
    #1;
    chk("jalr_flush", {31'b0, flush}, 32'h1);
    tick();
    chk("jalr_target", pc, 32'h1234);
    stall = 0;

    set_br(3'b011, 0, 32'h80, 32'h6, 32'h0);
    tick();
    chk("trap_pc_vec", pc, 32'h100);
    chk("trap_pulse", {31'b0, trap}, 32'h1);
    chk("trap_if_valid", {31'b0, if_valid}, 32'h0);
    chk("trap_pc_val", trap_pc, 32'h80);
    immgen = 32'h10;
    #1;
    chk("trap_no_flush", {31'b0, flush}, 32'h0);
    tick();
    chk("after_trap_pc", pc, 32'h100);
    chk("after_trap_pulse", {31'b0, trap}, 32'h0);
    ex_valid = 0;
    tick();
    chk("after_trap_seq", pc, 32'h104);
`ifdef PC_PERF_EN
    chk("perf_taken_lit", perf_taken, 32'd4);
    chk("perf_stall_lit", perf_stall, 32'd2);
`else
    chk("perf_taken_off", perf_taken, 32'd0);
    chk("perf_stall_off", perf_stall, 32'd0);
`endif

    set_br(3'b011, 0, 32'h0, 32'hFFFF_FFFC, 32'h0);
    tick();
    chk("top_pc", pc, 32'hFFFF_FFFC);
    chk("top_pc_4", pc_4, 32'h0);
    ex_valid = 0;
    tick();
    chk("wrap_pc", pc, 32'h0);

    stall = 1;
    tick();
    reset = 1;
    set_br(3'b011, 0, 32'h0, 32'h40, 32'h0);
    #1;
    chk("reset_flush", {31'b0, flush}, 32'h0);
    tick();
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_trap_pc", trap_pc, 32'h0);
    chk("mid_rst_if_valid", {31'b0, if_valid}, 32'h0);
    chk("mid_rst_taken", perf_taken, 32'h0);
    chk("mid_rst_stall", perf_stall, 32'h0);
    reset = 0;
    ex_valid = 0;
    stall = 0;
    tick();
    tick();
    chk("restart_pc", pc, 32'h4);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
